// File: rtl/acc_sequencer.sv
// acc_sequencer: sequences accelerator LOAD/SAVE/MOVE/MATMUL/RESET instructions against memory and the accelerator core
`ifndef LOAD
`define LOAD 3'b000
`endif
`ifndef SAVE
`define SAVE 3'b001
`endif
`ifndef MATMUL
`define MATMUL 3'b010
`endif
`ifndef RESET
`define RESET 3'b011
`endif
`ifndef MOVE
`define MOVE 3'b100
`endif
module acc_sequencer #(
  parameter int N_WORDS = 16,
  parameter int MM_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic issue_valid,
  input  logic [2:0] acc_op,
  input  logic [31:0] base_addr,
  output logic stall,
  output logic mem_req,
  output logic mem_we,
  output logic [31:0] mem_addr,
  input  logic mem_ack,
  output logic [$clog2(N_WORDS)-1:0] buf_idx,
  output logic in_buf_we,
  output logic res_buf_re,
  output logic mm_start,
  output logic acc_clear,
  input  logic mm_done,
  output logic done,
  output logic err
);
  localparam int IW = $clog2(N_WORDS);
  typedef enum logic [2:0] {IDLE, LD_XFER, SV_XFER, MV_XFER, MM_WAIT, DONE} state_t;
  state_t state, state_n;
  logic [31:0] base_q, timer;
  logic [IW-1:0] idx;
  logic last, step, issue, defined, mm_go, timeout;
  assign last = idx == IW'(N_WORDS - 1);
  assign step = ((state == LD_XFER || state == SV_XFER) && mem_ack) || state == MV_XFER;
  assign issue = state == IDLE && issue_valid && !rst;
  assign defined = acc_op inside {`LOAD, `SAVE, `MATMUL, `RESET, `MOVE};
  assign mm_go = state == MM_WAIT && timer != 32'd0 && mm_done;
  assign timeout = state == MM_WAIT && timer == 32'(MM_TIMEOUT) && !mm_done;
  assign stall = state == IDLE ? issue_valid : state != DONE;
  assign mem_req = state == LD_XFER || state == SV_XFER;
  assign mem_we = state == SV_XFER;
  assign mem_addr = base_q + 32'({idx, 2'b00});
  assign buf_idx = idx;
  assign in_buf_we = (state == LD_XFER && mem_ack) || state == MV_XFER;
  assign res_buf_re = state == SV_XFER || state == MV_XFER;
  assign mm_start = state == MM_WAIT && timer == 32'd0;
  assign acc_clear = issue && acc_op == `RESET;
  assign err = !rst && ((issue && !defined) || timeout);
  assign done = !rst && state == DONE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (issue_valid) state_n = acc_op == `LOAD ? LD_XFER : acc_op == `SAVE ? SV_XFER :
                                       acc_op == `MOVE ? MV_XFER : acc_op == `MATMUL ? MM_WAIT : DONE;
      LD_XFER, SV_XFER: if (mem_ack && last) state_n = DONE;
      MV_XFER: if (last) state_n = DONE;
      MM_WAIT: if (mm_go || timeout) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      timer <= '0;
      base_q <= '0;
    end else begin
      state <= state_n;
      timer <= state == MM_WAIT ? timer + 32'd1 : 32'd0;
      if (state == IDLE && issue_valid) begin
        base_q <= {base_addr[31:2], 2'b00};
        idx <= '0;
      end else if (step) idx <= idx + IW'(1);
    end
  end
endmodule

// File: tb/tb_acc_sequencer.sv
// tb_acc_sequencer: randomized self-checking bench for acc_sequencer against an operation-level model
`ifndef LOAD
`define LOAD 3'b000
`endif
`ifndef SAVE
`define SAVE 3'b001
`endif
`ifndef MATMUL
`define MATMUL 3'b010
`endif
`ifndef RESET
`define RESET 3'b011
`endif
`ifndef MOVE
`define MOVE 3'b100
`endif
module tb_acc_sequencer;
  localparam int N = 16;
  localparam int TO = 40;
  localparam int IW = 4;
  logic clk = 1'b0;
  logic rst, issue_valid, mem_ack, mm_done;
  logic [2:0] acc_op;
  logic [31:0] base_addr, mem_addr;
  logic stall, mem_req, mem_we, in_buf_we, res_buf_re, mm_start, acc_clear, done, err;
  logic [IW-1:0] buf_idx;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  acc_sequencer #(.N_WORDS(N), .MM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .acc_op(acc_op), .base_addr(base_addr),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .buf_idx(buf_idx), .in_buf_we(in_buf_we), .res_buf_re(res_buf_re), .mm_start(mm_start),
    .acc_clear(acc_clear), .mm_done(mm_done), .done(done), .err(err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic do_op(input logic [2:0] op, input logic [31:0] base, input int pct, input int lat);
    logic [31:0] al;
    int k, mm_end;
    bit fin, act, mv, mm, busy, ld, sv, undef, mm_ok;
    al = {base[31:2], 2'b00};
    k = 0;
    fin = 0;
    ld = op == `LOAD;
    sv = op == `SAVE;
    undef = !(op inside {`LOAD, `SAVE, `MATMUL, `RESET, `MOVE});
    mm_ok = lat >= 1 && lat <= TO;
    mm_end = mm_ok ? 1 + lat : 1 + TO;
    for (int cyc = 0; !fin && cyc < 4000; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        issue_valid = 1'b1;
        acc_op = op;
        base_addr = base;
      end else begin
        issue_valid = 1'($urandom_range(1));
        acc_op = 3'($urandom);
        base_addr = $urandom;
      end
      mem_ack = pct < 0 ? (cyc % 3 == 0) : ($urandom_range(99) < pct);
      mm_done = op == `MATMUL ? (cyc == 1 || (lat >= 0 && cyc == 1 + lat)) : 1'($urandom_range(1));
      #1;
      act = (ld || sv) && cyc >= 1 && k < N;
      mv = op == `MOVE && cyc >= 1 && cyc <= N;
      mm = op == `MATMUL && cyc >= 1 && cyc <= mm_end;
      busy = cyc == 0 || act || mv || mm;
      chk("stall", 32'(stall), 32'(busy));
      chk("done", 32'(done), 32'(!busy));
      chk("mem_req", 32'(mem_req), 32'(act));
      if (act) begin
        chk("mem_addr", mem_addr, al + 32'(4 * k));
        chk("mem_we", 32'(mem_we), 32'(sv));
        chk("buf_idx", 32'(buf_idx), 32'(k));
      end
      if (mv) chk("mv_idx", 32'(buf_idx), 32'(cyc - 1));
      chk("in_buf_we", 32'(in_buf_we), 32'((act && ld && mem_ack) || mv));
      chk("res_buf_re", 32'(res_buf_re), 32'((act && sv) || mv));
      chk("mm_start", 32'(mm_start), 32'(op == `MATMUL && cyc == 1));
      chk("acc_clear", 32'(acc_clear), 32'(op == `RESET && cyc == 0));
      chk("err", 32'(err), 32'((cyc == 0 && undef) || (op == `MATMUL && !mm_ok && cyc == 1 + TO)));
      if (act && mem_ack) k++;
      if (!busy) fin = 1;
    end
    if (!fin) chk("op_budget", 32'(fin), 32'd1);
    @(negedge clk);
    issue_valid = 1'b0;
    mem_ack = 1'b0;
    mm_done = 1'b0;
    #1;
    chk("idle_stall", 32'(stall), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_req", 32'(mem_req), 32'd0);
  endtask
  initial begin
    rst = 1'b1;
    issue_valid = 1'b0;
    acc_op = 3'b000;
    base_addr = 32'h0;
    mem_ack = 1'b0;
    mm_done = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_idx", 32'(buf_idx), 32'd0);
    chk("rst_strobes", {28'd0, in_buf_we, res_buf_re, mm_start, acc_clear}, 32'd0);
    chk("rst_done_err", {30'd0, done, err}, 32'd0);
    @(negedge clk);
    issue_valid = 1'b1;
    acc_op = `RESET;
    #1;
    chk("rst_stall_follow", 32'(stall), 32'd1);
    chk("rst_no_clear", 32'(acc_clear), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    issue_valid = 1'b0;
    do_op(`LOAD, 32'h0000_1003, 100, 0);
    do_op(`SAVE, 32'h0000_2000, -1, 0);
    do_op(`MATMUL, 32'h0, 100, 5);
    do_op(`MATMUL, 32'h0, 100, -1);
    do_op(`RESET, 32'h0, 100, 0);
    do_op(3'b111, 32'h0, 100, 0);
    do_op(`LOAD, 32'hFFFF_FFF8, 100, 0);
    do_op(`MOVE, 32'h0, 100, 0);
    @(negedge clk);
    issue_valid = 1'b1;
    acc_op = `LOAD;
    base_addr = 32'h0000_3000;
    mem_ack = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      issue_valid = 1'b0;
      if (c == 8) rst = 1'b1;
    end
    #1;
    chk("abort_idx", 32'(buf_idx), 32'd7);
    chk("abort_addr", mem_addr, 32'h0000_301C);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_req", 32'(mem_req), 32'd0);
    chk("abort_we", 32'(in_buf_we), 32'd0);
    chk("abort_stall", 32'(stall), 32'd0);
    chk("abort_idx0", 32'(buf_idx), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk("abort_nodone", {30'd0, done, err}, 32'd0);
    end
    do_op(`LOAD, 32'h0000_3000, 100, 0);
    for (int i = 0; i < 25; i++)
      do_op(3'($urandom), $urandom, int'($urandom_range(30, 100)), int'($urandom_range(0, TO + 3)));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/acc_sequencer.md
ACC_SEQUENCER -- requirements
Module: acc_sequencer

Interface
REQ-001 Parameter N_WORDS, default 16: words per accelerator buffer transfer; power of two, 2..256.
REQ-002 Parameter MM_TIMEOUT, default 1024: maximum cycles allowed between mm_start and mm_done.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 issue_valid  in  1  decoded accelerator instruction present in execute stage.
REQ-006 acc_op  in  3  funct3 of the instruction; encodings are the project `LOAD, `SAVE, `MATMUL, `RESET, `MOVE defines.
REQ-007 base_addr  in  32  rs1 value; byte address of the memory block.
REQ-008 stall  out  1  holds the core pipeline.
REQ-009 mem_req, mem_we  out  1 each  data-memory request and write strobe.
REQ-010 mem_addr  out  32  word-aligned data-memory address.
REQ-011 mem_ack  in  1  memory completes the current request this cycle.
REQ-012 buf_idx  out  log2(N_WORDS)  accelerator buffer word index.
REQ-013 in_buf_we, res_buf_re  out  1 each  input-buffer write strobe, result-buffer read strobe.
REQ-014 mm_start, acc_clear  out  1 each  one-cycle pulses to the accelerator core.
REQ-015 mm_done  in  1  accelerator core finished a multiply.
REQ-016 done, err  out  1 each  one-cycle completion pulse; one-cycle error pulse.

Function
REQ-017 States: IDLE, LD_XFER, SV_XFER, MV_XFER, MM_WAIT, DONE.
REQ-018 In IDLE, stall = issue_valid; in LD_XFER, SV_XFER, MV_XFER, MM_WAIT stall = 1; in DONE stall = 0.
REQ-019 IDLE with issue_valid: latch acc_op and {base_addr[31:2],2'b00}, clear idx to 0, go to the state for the op next cycle.
REQ-020 `LOAD -> LD_XFER: mem_req=1, mem_we=0, mem_addr=base+4*idx; on mem_ack, in_buf_we=1 same cycle, idx increments.
REQ-021 `SAVE -> SV_XFER: res_buf_re=1, mem_req=1, mem_we=1, mem_addr=base+4*idx; idx increments on mem_ack.
REQ-022 mem_addr, mem_we and buf_idx SHALL stay stable while mem_req=1 and mem_ack=0.
REQ-023 LD_XFER/SV_XFER exit to DONE on the mem_ack with idx = N_WORDS-1; idx wraps to 0.
REQ-024 `MOVE -> MV_XFER: res_buf_re=1 and in_buf_we=1 every cycle, no memory request; idx increments each cycle; exit to DONE after N_WORDS cycles.
REQ-025 `MATMUL -> MM_WAIT: mm_start=1 in the first MM_WAIT cycle only; exit to DONE on mm_done.
REQ-026 mm_done sampled in the same cycle as mm_start SHALL be ignored.
REQ-027 MM_WAIT: a 32-bit timer counts from mm_start; reaching MM_TIMEOUT without mm_done -> err=1 one cycle, go to DONE.
REQ-028 `RESET: acc_clear=1 for one cycle in the issue cycle; next state DONE directly.
REQ-029 Undefined acc_op: err=1 in the issue cycle, stall=1 that cycle, next state DONE.
REQ-030 DONE: done=1 for exactly one cycle, then IDLE; issue_valid in DONE SHALL be ignored.
REQ-031 issue_valid outside IDLE SHALL be ignored; latched op/address SHALL not change.
REQ-032 mem_addr arithmetic is 32-bit modulo; overflow past 0xFFFFFFFC wraps to 0 with no error.
REQ-033 With mem_ack always 1, LOAD/SAVE stall = N_WORDS+1 cycles; MOVE stall = N_WORDS+1 cycles.

Reset
REQ-034 rst=1 at a clock edge: state IDLE, idx=0, timer=0, latched op/address=0.
REQ-035 Reset values: all outputs 0, except stall, which follows issue_valid in IDLE.
REQ-036 rst mid-operation aborts: no done, no err, no further mem_req or buffer strobes from the next cycle; rst has priority over all inputs.

Verification
REQ-037 LOAD, base=0x1003, mem_ack=1 always -> addresses 0x1000..0x103C, 16 in_buf_we pulses idx 0..15, done at cycle 17, stall cycles = 17.
REQ-038 SAVE, base=0x2000, mem_ack every third cycle -> each address held until ack, 16 writes, done once, no address skip.
REQ-039 MATMUL, mm_done 5 cycles after mm_start -> one mm_start pulse, done 1 cycle after mm_done, err=0; no mm_done -> err and done at MM_TIMEOUT.
REQ-040 RESET -> acc_clear one cycle, done next cycle, no mem_req; undefined acc_op=3'b111 -> err in issue cycle, done next cycle.
REQ-041 LOAD, base=0xFFFFFFF8 -> addresses wrap to 0x00000000 after 0xFFFFFFFC.
REQ-042 rst asserted during LD_XFER with idx=7 -> next cycle IDLE, mem_req=0, no done; new LOAD then restarts at idx=0.
